// File: rtl/avm_rd_burst_master_if.sv
// Bundle of the DMA command/data bus and the Avalon-MM read master signals.
// master : view of the burst master (drives rrdy, rdata/rdval and the Avalon request)
// slave  : view of the surroundings (DMA engine plus Avalon fabric)
// Ports:
//   bus_rrdy/bus_rval/bus_rlen/bus_raddr   burst command from the DMA
//   bus_rdata/bus_rdval                    read data back to the DMA
//   avm_read/avm_address/avm_burstcount    Avalon request
//   avm_waitrequest                        Avalon stall
//   avm_readdata/avm_readdatavalid         Avalon read return
interface avm_rd_burst_master_if #(
    parameter int AW = 32,
    parameter int DW = 64,
    parameter int BL = 4
) ();
    logic          bus_rrdy;
    logic          bus_rval;
    logic [BL-1:0] bus_rlen;
    logic [AW-1:0] bus_raddr;
    logic [DW-1:0] bus_rdata;
    logic          bus_rdval;
    logic          avm_read;
    logic [AW-1:0] avm_address;
    logic [BL:0]   avm_burstcount;
    logic          avm_waitrequest;
    logic [DW-1:0] avm_readdata;
    logic          avm_readdatavalid;

    modport master (
        output bus_rrdy,
        input  bus_rval,
        input  bus_rlen,
        input  bus_raddr,
        output bus_rdata,
        output bus_rdval,
        output avm_read,
        output avm_address,
        output avm_burstcount,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  bus_rrdy,
        output bus_rval,
        output bus_rlen,
        output bus_raddr,
        input  bus_rdata,
        input  bus_rdval,
        input  avm_read,
        input  avm_address,
        input  avm_burstcount,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/avm_rd_burst_master.sv
// Avalon-MM burst read master between the frame-read DMA engine and the
// Avalon interconnect. A one-cycle burst command becomes one Avalon read
// request; words in flight are tracked as credit so the master never has
// more than MAX_OUTST words outstanding. Read data is forwarded to the DMA
// with one registered cycle of latency and no backpressure.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bif          command/data bus and Avalon master signals (master modport)
//   err_clr      clears the sticky error flags
//   err          [0] misaligned command address, [1] readdatavalid with nothing outstanding
//   busy         request pending or words still outstanding
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no request on Avalon; a command may be accepted
// S_REQ  | avm_read asserted, address/burstcount held until waitrequest=0
module avm_rd_burst_master #(
    parameter int AW        = 32,
    parameter int DW        = 64,
    parameter int BL        = 4,
    parameter int MAX_OUTST = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    avm_rd_burst_master_if.master  bif,
    input  logic                   err_clr,
    output logic [1:0]             err,
    output logic                   busy
);
    localparam int OW = $clog2(MAX_OUTST + 1);
    // Byte-offset bits inside one data word.
    localparam logic [AW-1:0] LOW_MASK   = AW'(DW / 8 - 1);
    // A new burst of maximum size must still fit in the credit budget.
    localparam logic [OW-1:0] RRDY_LIMIT = OW'(MAX_OUTST - 2 ** BL);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [0:0]    state;
    logic [OW-1:0] outst;
    logic [OW-1:0] outst_add;
    logic [OW-1:0] outst_sub;
    logic [BL:0]   burst_len;
    logic          accept;
    logic          misaligned;
    logic          spurious;
    logic          ret_word;

    assign bif.avm_read = (state == S_REQ);
    assign bif.bus_rrdy = (state == S_IDLE) && (outst <= RRDY_LIMIT);
    assign busy         = bif.avm_read | (outst != '0);

    assign accept     = bif.bus_rval & bif.bus_rrdy;
    assign burst_len  = {1'b0, bif.bus_rlen} + {{BL{1'b0}}, 1'b1};
    assign misaligned = accept & ((bif.bus_raddr & LOW_MASK) != '0);
    // A return with no credit outstanding is flagged and must not wrap the counter.
    assign spurious   = bif.avm_readdatavalid & (outst == '0);
    assign ret_word   = bif.avm_readdatavalid & (outst != '0);

    assign outst_add  = accept   ? OW'(burst_len) : '0;
    assign outst_sub  = ret_word ? OW'(1)         : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept) state <= S_REQ;
                S_REQ:   if (!bif.avm_waitrequest) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bif.avm_address    <= '0;
            bif.avm_burstcount <= {{BL{1'b0}}, 1'b1};
        end else if (accept) begin
            bif.avm_address    <= bif.bus_raddr & ~LOW_MASK;
            bif.avm_burstcount <= burst_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst <= '0;
        end else begin
            outst <= outst + outst_add - outst_sub;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bif.bus_rdval <= 1'b0;
            bif.bus_rdata <= '0;
        end else begin
            bif.bus_rdval <= bif.avm_readdatavalid;
            if (bif.avm_readdatavalid) bif.bus_rdata <= bif.avm_readdata;
        end
    end

    // A new error event takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 2'b00;
        end else begin
            err <= {spurious, misaligned} | (err & {2{~err_clr}});
        end
    end
endmodule

// File: tb/tb_avm_rd_burst_master.sv
module tb_avm_rd_burst_master;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BL = 4;
    localparam int MAX_OUTST = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_clr = 1'b0;
    logic [1:0] err;
    logic       busy;

    int n_chk = 0;
    int n_pass = 0;

    // behavioural reference state
    int          m_outst;
    bit          m_read;
    logic [31:0] m_addr;
    int          m_bc;
    logic [1:0]  m_err;
    logic        m_rdval;
    logic [63:0] m_rdata;

    avm_rd_burst_master_if #(.AW(AW), .DW(DW), .BL(BL)) bif ();

    avm_rd_burst_master #(.AW(AW), .DW(DW), .BL(BL), .MAX_OUTST(MAX_OUTST)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bif     (bif),
        .err_clr (err_clr),
        .err     (err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic bit m_rrdy();
        return !m_read && (m_outst <= MAX_OUTST - 16);
    endfunction

    task automatic model_reset();
        m_outst = 0; m_read = 0; m_addr = '0; m_bc = 1;
        m_err = 2'b00; m_rdval = 0; m_rdata = '0;
    endtask

    task automatic idle_inputs();
        bif.bus_rval = 0; bif.bus_rlen = '0; bif.bus_raddr = '0;
        bif.avm_waitrequest = 0; bif.avm_readdata = '0; bif.avm_readdatavalid = 0;
        err_clr = 0;
    endtask

    // advance one clock, updating the reference model from the inputs in force
    task automatic tick();
        bit   acc;
        int   len;
        bit   rdv;
        int   n_outst;
        bit   n_read;
        logic [1:0] n_err;
        acc = bif.bus_rval && m_rrdy();
        len = int'(bif.bus_rlen) + 1;
        rdv = bif.avm_readdatavalid;
        n_outst = m_outst + (acc ? len : 0) - ((rdv && m_outst > 0) ? 1 : 0);
        n_read  = acc ? 1'b1 : (m_read && bif.avm_waitrequest);
        n_err[0] = (acc && (bif.bus_raddr % 8 != 0)) || (m_err[0] && !err_clr);
        n_err[1] = (rdv && m_outst == 0) || (m_err[1] && !err_clr);
        if (acc) begin
            m_addr = bif.bus_raddr - (bif.bus_raddr % 8);
            m_bc   = len;
        end
        if (rdv) m_rdata = bif.avm_readdata;
        m_rdval = rdv;
        m_outst = n_outst;
        m_read  = n_read;
        m_err   = n_err;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int rlen, input logic [31:0] addr);
        bif.bus_rval = 1; bif.bus_rlen = BL'(rlen); bif.bus_raddr = addr;
        tick();
        bif.bus_rval = 0;
    endtask

    task automatic finish_req();
        bif.avm_waitrequest = 0;
        for (int i = 0; i < 20 && m_read; i++) tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && m_outst > 0; i++) begin
            bif.avm_readdatavalid = 1;
            bif.avm_readdata = {$urandom, $urandom};
            tick();
        end
        bif.avm_readdatavalid = 0;
        tick();
    endtask

    task automatic test_reset();
        n_chk++; if (bif.avm_read !== 1'b0) $display("FAIL rst_read act=%0b exp=0", bif.avm_read); else n_pass++;
        n_chk++; if (bif.avm_address !== 32'h0) $display("FAIL rst_addr act=%0h exp=0", bif.avm_address); else n_pass++;
        n_chk++; if (bif.avm_burstcount !== 5'd1) $display("FAIL rst_bc act=%0d exp=1", bif.avm_burstcount); else n_pass++;
        n_chk++; if (bif.bus_rdata !== 64'h0) $display("FAIL rst_rdata act=%0h exp=0", bif.bus_rdata); else n_pass++;
        n_chk++; if (bif.bus_rdval !== 1'b0) $display("FAIL rst_rdval act=%0b exp=0", bif.bus_rdval); else n_pass++;
        n_chk++; if (err !== 2'b00) $display("FAIL rst_err act=%b exp=00", err); else n_pass++;
        n_chk++; if (dut.outst !== 6'd0) $display("FAIL rst_outst act=%0d exp=0", dut.outst); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy act=%0b exp=0", busy); else n_pass++;
        n_chk++; if (bif.bus_rrdy !== 1'b1) $display("FAIL rst_rrdy act=%0b exp=1", bif.bus_rrdy); else n_pass++;
    endtask

    task automatic test_single_burst();
        logic [63:0] d;
        n_chk++; if (bif.avm_read !== 1'b0) $display("FAIL single_pre_read act=%0b exp=0", bif.avm_read); else n_pass++;
        issue(3, 32'h1000);
        n_chk++; if (bif.avm_read !== 1'b1) $display("FAIL single_read act=%0b exp=1", bif.avm_read); else n_pass++;
        n_chk++; if (bif.avm_address !== 32'h1000) $display("FAIL single_addr act=%0h exp=1000", bif.avm_address); else n_pass++;
        n_chk++; if (bif.avm_burstcount !== 5'd4) $display("FAIL single_bc act=%0d exp=4", bif.avm_burstcount); else n_pass++;
        n_chk++; if (dut.outst !== 6'd4) $display("FAIL single_outst act=%0d exp=4", dut.outst); else n_pass++;
        n_chk++; if (bif.bus_rrdy !== 1'b0) $display("FAIL single_rrdy act=%0b exp=0", bif.bus_rrdy); else n_pass++;
        tick();
        n_chk++; if (bif.avm_read !== 1'b0) $display("FAIL single_read_drop act=%0b exp=0", bif.avm_read); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            bif.avm_readdatavalid = 1; bif.avm_readdata = d;
            tick();
            n_chk++; if (bif.bus_rdval !== 1'b1) $display("FAIL single_rdval%0d act=%0b exp=1", i, bif.bus_rdval); else n_pass++;
            n_chk++; if (bif.bus_rdata !== d) $display("FAIL single_rdata%0d act=%0h exp=%0h", i, bif.bus_rdata, d); else n_pass++;
        end
        bif.avm_readdatavalid = 0;
        tick();
        n_chk++; if (dut.outst !== 6'd0) $display("FAIL single_outst_end act=%0d exp=0", dut.outst); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL single_busy_end act=%0b exp=0", busy); else n_pass++;
        n_chk++; if (bif.bus_rdval !== 1'b0) $display("FAIL single_rdval_end act=%0b exp=0", bif.bus_rdval); else n_pass++;
    endtask

    task automatic test_stall();
        issue(1, 32'h2000);
        bif.avm_waitrequest = 1;
        bif.bus_rval = 1; bif.bus_rlen = 4'd5; bif.bus_raddr = 32'h3000;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bif.avm_waitrequest = 0;
            n_chk++; if (bif.avm_read !== 1'b1) $display("FAIL stall_read%0d act=%0b exp=1", c, bif.avm_read); else n_pass++;
            n_chk++; if (bif.avm_address !== 32'h2000) $display("FAIL stall_addr%0d act=%0h exp=2000", c, bif.avm_address); else n_pass++;
            n_chk++; if (bif.avm_burstcount !== 5'd2) $display("FAIL stall_bc%0d act=%0d exp=2", c, bif.avm_burstcount); else n_pass++;
            n_chk++; if (bif.bus_rrdy !== 1'b0) $display("FAIL stall_rrdy%0d act=%0b exp=0", c, bif.bus_rrdy); else n_pass++;
            if (c == 3) bif.bus_rval = 0;
            tick();
        end
        n_chk++; if (bif.avm_read !== 1'b0) $display("FAIL stall_read_drop act=%0b exp=0", bif.avm_read); else n_pass++;
        n_chk++; if (dut.outst !== 6'd2) $display("FAIL stall_outst act=%0d exp=2", dut.outst); else n_pass++;
        drain();
    endtask

    task automatic test_credit_limit();
        issue(15, 32'h4000);
        finish_req();
        n_chk++; if (bif.bus_rrdy !== 1'b1) $display("FAIL credit_rrdy16 act=%0b exp=1", bif.bus_rrdy); else n_pass++;
        issue(15, 32'h5000);
        finish_req();
        n_chk++; if (dut.outst !== 6'd32) $display("FAIL credit_outst act=%0d exp=32", dut.outst); else n_pass++;
        n_chk++; if (bif.bus_rrdy !== 1'b0) $display("FAIL credit_rrdy32 act=%0b exp=0", bif.bus_rrdy); else n_pass++;
        for (int k = 1; k <= 16; k++) begin
            bif.avm_readdatavalid = 1; bif.avm_readdata = {$urandom, $urandom};
            tick();
            n_chk++; if (bif.bus_rrdy !== (k == 16)) $display("FAIL credit_rrdy_after%0d act=%0b exp=%0b", k, bif.bus_rrdy, k == 16); else n_pass++;
        end
        bif.avm_readdatavalid = 0;
        drain();
    endtask

    task automatic test_simultaneous();
        issue(4, 32'h6000);
        finish_req();
        n_chk++; if (dut.outst !== 6'd5) $display("FAIL simul_pre act=%0d exp=5", dut.outst); else n_pass++;
        bif.avm_readdatavalid = 1; bif.avm_readdata = 64'h1234;
        issue(7, 32'h7000);
        bif.avm_readdatavalid = 0;
        n_chk++; if (dut.outst !== 6'd12) $display("FAIL simul_outst act=%0d exp=12", dut.outst); else n_pass++;
        finish_req();
        drain();
    endtask

    task automatic test_misaligned();
        issue(0, 32'h1004);
        n_chk++; if (bif.avm_address !== 32'h1000) $display("FAIL mis_addr act=%0h exp=1000", bif.avm_address); else n_pass++;
        n_chk++; if (err !== 2'b01) $display("FAIL mis_err act=%b exp=01", err); else n_pass++;
        finish_req();
        err_clr = 1; tick(); err_clr = 0;
        n_chk++; if (err !== 2'b00) $display("FAIL mis_clr act=%b exp=00", err); else n_pass++;
        drain();
        issue(0, 32'h1000);
        finish_req();
        err_clr = 1;
        issue(1, 32'h2003);
        err_clr = 0;
        n_chk++; if (err !== 2'b01) $display("FAIL mis_set_wins act=%b exp=01", err); else n_pass++;
        finish_req();
        drain();
        err_clr = 1; tick(); err_clr = 0;
    endtask

    task automatic test_spurious_reset();
        bif.avm_readdatavalid = 1; bif.avm_readdata = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        bif.avm_readdatavalid = 0;
        n_chk++; if (err !== 2'b10) $display("FAIL spur_err act=%b exp=10", err); else n_pass++;
        n_chk++; if (dut.outst !== 6'd0) $display("FAIL spur_outst act=%0d exp=0", dut.outst); else n_pass++;
        n_chk++; if (bif.bus_rdval !== 1'b1) $display("FAIL spur_rdval act=%0b exp=1", bif.bus_rdval); else n_pass++;
        n_chk++; if (bif.bus_rdata !== 64'hDEAD_BEEF_0BAD_F00D) $display("FAIL spur_rdata act=%0h exp=deadbeef0badf00d", bif.bus_rdata); else n_pass++;
        err_clr = 1; tick(); err_clr = 0;
        issue(2, 32'h8000);
        bif.avm_waitrequest = 1;
        tick();
        n_chk++; if (bif.avm_read !== 1'b1) $display("FAIL areset_pre act=%0b exp=1", bif.avm_read); else n_pass++;
        #2 rst_n = 0;
        #1;
        n_chk++; if (bif.avm_read !== 1'b0) $display("FAIL areset_read act=%0b exp=0", bif.avm_read); else n_pass++;
        n_chk++; if (dut.outst !== 6'd0) $display("FAIL areset_outst act=%0d exp=0", dut.outst); else n_pass++;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bif.bus_rval = ($urandom % 2) == 0;
            bif.bus_rlen = BL'($urandom);
            bif.bus_raddr = $urandom;
            bif.avm_waitrequest = ($urandom % 3) == 0;
            bif.avm_readdatavalid = (m_outst > 0) && (($urandom % 2) == 0);
            bif.avm_readdata = {$urandom, $urandom};
            err_clr = ($urandom % 8) == 0;
            tick();
            n_chk++; if (bif.avm_read !== m_read) $display("FAIL rnd_read%0d act=%0b exp=%0b", i, bif.avm_read, m_read); else n_pass++;
            n_chk++; if (int'(dut.outst) != m_outst) $display("FAIL rnd_outst%0d act=%0d exp=%0d", i, dut.outst, m_outst); else n_pass++;
            n_chk++; if (bif.bus_rrdy !== m_rrdy()) $display("FAIL rnd_rrdy%0d act=%0b exp=%0b", i, bif.bus_rrdy, m_rrdy()); else n_pass++;
            n_chk++; if (bif.bus_rdval !== m_rdval) $display("FAIL rnd_rdval%0d act=%0b exp=%0b", i, bif.bus_rdval, m_rdval); else n_pass++;
            n_chk++; if (bif.bus_rdata !== m_rdata) $display("FAIL rnd_rdata%0d act=%0h exp=%0h", i, bif.bus_rdata, m_rdata); else n_pass++;
            n_chk++; if (err !== m_err) $display("FAIL rnd_err%0d act=%b exp=%b", i, err, m_err); else n_pass++;
            n_chk++; if (busy !== (m_read || m_outst != 0)) $display("FAIL rnd_busy%0d act=%0b exp=%0b", i, busy, m_read || m_outst != 0); else n_pass++;
            if (m_read) begin
                n_chk++; if (bif.avm_address !== m_addr) $display("FAIL rnd_addr%0d act=%0h exp=%0h", i, bif.avm_address, m_addr); else n_pass++;
                n_chk++; if (int'(bif.avm_burstcount) != m_bc) $display("FAIL rnd_bc%0d act=%0d exp=%0d", i, bif.avm_burstcount, m_bc); else n_pass++;
            end
        end
        bif.bus_rval = 0;
        err_clr = 0;
        finish_req();
        drain();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        test_reset();
        test_single_burst();
        test_stall();
        test_credit_limit();
        test_simultaneous();
        test_misaligned();
        test_spurious_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
